// File: rtl/bus_pipe_array.sv
// Elastic DEPTH-stage pipeline for a CHANNELS x WIDTH bus with collapsing bubbles,
// an occupancy count and a synchronous flush that drops valid bits but keeps data.
module bus_pipe_array #(
    parameter  int unsigned WIDTH    = 8,
    parameter  int unsigned CHANNELS = 4,
    parameter  int unsigned DEPTH    = 2,
    localparam int unsigned DW       = WIDTH * CHANNELS,
    localparam int unsigned CW       = $clog2(DEPTH + 1)
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          FLUSH,
    input  logic          IN_VALID,
    output logic          IN_READY,
    input  logic [DW-1:0] IN_DATA,
    output logic          OUT_VALID,
    input  logic          OUT_READY,
    output logic [DW-1:0] OUT_DATA,
    output logic [CW-1:0] COUNT
);

    if (DEPTH < 1 || WIDTH < 1 || CHANNELS < 1) begin : g_param_check
        $error("bus_pipe_array: DEPTH, WIDTH and CHANNELS must all be >= 1");
    end

    logic [DEPTH-1:0] v;
    logic [DW-1:0]    d [DEPTH];
    logic [DEPTH:0]   r;
    logic [DEPTH-1:0] up_v;
    logic [DW-1:0]    up_d [DEPTH];
    logic [CW-1:0]    count;
    logic             in_xfer;
    logic             out_xfer;

    // A stage can take a word if it is empty or its own word moves on.
    always_comb begin : ready_chain
        r        = '0;
        r[DEPTH] = OUT_READY;
        for (int i = int'(DEPTH) - 1; i >= 0; i--) begin
            r[i] = !v[i] || r[i+1];
        end
    end

    always_comb begin : upstream
        up_v[0] = IN_VALID;
        up_d[0] = IN_DATA;
        for (int i = 1; i < int'(DEPTH); i++) begin
            up_v[i] = v[i-1];
            up_d[i] = d[i-1];
        end
    end

    assign IN_READY  = r[0] & ~FLUSH & ~RST;
    assign in_xfer   = IN_VALID & IN_READY;
    assign out_xfer  = v[DEPTH-1] & OUT_READY;
    assign OUT_VALID = v[DEPTH-1];
    assign OUT_DATA  = d[DEPTH-1];
    assign COUNT     = count;

    always_ff @(posedge CLK) begin : stages
        if (RST) begin
            v     <= '0;
            count <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                d[i] <= '0;
            end
        end else if (FLUSH) begin
            v     <= '0;
            count <= '0;
        end else begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                if (r[i]) begin
                    v[i] <= up_v[i];
                    // Empty slots arriving from upstream leave the old data in place.
                    if (up_v[i]) begin
                        d[i] <= up_d[i];
                    end
                end
            end
            if (in_xfer && !out_xfer) begin
                count <= count + CW'(1);
            end else if (out_xfer && !in_xfer) begin
                count <= count - CW'(1);
            end
        end
    end

endmodule

// File: tb/tb_bus_pipe_array.sv
// Bench for bus_pipe_array: directed vector tables for a 3-deep and a 1-deep instance,
// then random traffic on the 3-deep instance against a queue-based reference model.
module tb_bus_pipe_array;

    localparam int unsigned D = 3;

    typedef struct {
        logic        rst;
        logic        flush;
        logic        in_valid;
        logic [31:0] in_data;
        logic        out_ready;
        logic        exp_ready;
        logic        exp_valid;
        logic [31:0] exp_data;
        logic [1:0]  exp_count;
    } vec_t;

    typedef struct {
        logic [31:0] data;
        int          pos;
    } word_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1, flush = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
    logic [31:0] in_data = '0;
    logic        in_ready, out_valid;
    logic [31:0] out_data;
    logic [1:0]  count;

    logic        e_rst = 1'b1, e_flush = 1'b0, e_in_valid = 1'b0, e_out_ready = 1'b0;
    logic [0:0]  e_in_data = '0;
    logic        e_in_ready, e_out_valid;
    logic [0:0]  e_out_data;
    logic [0:0]  e_count;

    int n_checks = 0;
    int n_pass   = 0;

    vec_t  main_tbl[$];
    vec_t  edge_tbl[$];
    word_t mq[$];
    logic [31:0] m_last;

    always #5 clk = ~clk;

    bus_pipe_array #(.WIDTH(8), .CHANNELS(4), .DEPTH(D)) dut (
        .CLK(clk), .RST(rst), .FLUSH(flush),
        .IN_VALID(in_valid), .IN_READY(in_ready), .IN_DATA(in_data),
        .OUT_VALID(out_valid), .OUT_READY(out_ready), .OUT_DATA(out_data),
        .COUNT(count)
    );

    bus_pipe_array #(.WIDTH(1), .CHANNELS(1), .DEPTH(1)) dut_edge (
        .CLK(clk), .RST(e_rst), .FLUSH(e_flush),
        .IN_VALID(e_in_valid), .IN_READY(e_in_ready), .IN_DATA(e_in_data),
        .OUT_VALID(e_out_valid), .OUT_READY(e_out_ready), .OUT_DATA(e_out_data),
        .COUNT(e_count)
    );

    function automatic vec_t mk(logic r, logic f, logic iv, logic [31:0] dat, logic ordy,
                                logic er, logic ev, logic [31:0] ed, logic [1:0] ec);
        vec_t t;
        t.rst = r; t.flush = f; t.in_valid = iv; t.in_data = dat; t.out_ready = ordy;
        t.exp_ready = er; t.exp_valid = ev; t.exp_data = ed; t.exp_count = ec;
        return t;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Words advance one slot per cycle toward the output unless the slot ahead stays taken.
    function automatic vec_t model_step(logic r, logic f, logic iv, logic [31:0] dat, logic ordy);
        vec_t t;
        t = mk(r, f, iv, dat, ordy, 1'b0, 1'b0, '0, '0);
        t.exp_ready = !r && !f && (mq.size() < int'(D) || ordy);
        if (r) begin
            mq.delete();
            m_last = '0;
        end else if (f) begin
            mq.delete();
        end else begin
            if (mq.size() > 0 && mq[0].pos == int'(D) - 1 && ordy) void'(mq.pop_front());
            for (int j = 0; j < mq.size(); j++) begin
                int lim;
                lim = (j == 0) ? int'(D) - 1 : mq[j-1].pos - 1;
                if (mq[j].pos < lim) mq[j].pos = mq[j].pos + 1;
            end
            if (iv && t.exp_ready) begin
                word_t w;
                w.data = dat;
                w.pos  = 0;
                mq.push_back(w);
            end
            if (mq.size() > 0 && mq[0].pos == int'(D) - 1) m_last = mq[0].data;
        end
        t.exp_valid = mq.size() > 0 && mq[0].pos == int'(D) - 1;
        t.exp_data  = m_last;
        t.exp_count = 2'(mq.size());
        return t;
    endfunction

    task automatic apply_main(input vec_t t, input string tag);
        rst = t.rst; flush = t.flush; in_valid = t.in_valid;
        in_data = t.in_data; out_ready = t.out_ready;
        #1;
        chk({tag, " in_ready"}, 32'(in_ready), 32'(t.exp_ready));
        @(posedge clk);
        @(negedge clk);
        chk({tag, " out_valid"}, 32'(out_valid), 32'(t.exp_valid));
        chk({tag, " out_data"}, out_data, t.exp_data);
        chk({tag, " count"}, 32'(count), 32'(t.exp_count));
    endtask

    task automatic apply_edge(input vec_t t, input string tag);
        e_rst = t.rst; e_flush = t.flush; e_in_valid = t.in_valid;
        e_in_data = t.in_data[0:0]; e_out_ready = t.out_ready;
        #1;
        chk({tag, " in_ready"}, 32'(e_in_ready), 32'(t.exp_ready));
        @(posedge clk);
        @(negedge clk);
        chk({tag, " out_valid"}, 32'(e_out_valid), 32'(t.exp_valid));
        chk({tag, " out_data"}, 32'(e_out_data), 32'(t.exp_data));
        chk({tag, " count"}, 32'(e_count), 32'(t.exp_count));
    endtask

    initial begin
        // Reset with a word on the input: nothing may be captured.
        main_tbl.push_back(mk(1, 0, 1, 32'hDEADBEEF, 1, 0, 0, 32'h0, 0));
        main_tbl.push_back(mk(1, 0, 1, 32'hDEADBEEF, 1, 0, 0, 32'h0, 0));
        main_tbl.push_back(mk(0, 0, 0, 32'h0, 0, 1, 0, 32'h0, 0));
        // Back-to-back streaming, then drain.
        for (int k = 1; k <= 16; k++) begin
            main_tbl.push_back(mk(0, 0, 1, 32'(k), 1, 1, k >= 3,
                                  (k >= 3) ? 32'(k - 2) : 32'h0, (k < 3) ? 2'(k) : 2'd3));
        end
        main_tbl.push_back(mk(0, 0, 0, 32'h0, 1, 1, 1, 32'd15, 2));
        main_tbl.push_back(mk(0, 0, 0, 32'h0, 1, 1, 1, 32'd16, 1));
        main_tbl.push_back(mk(0, 0, 0, 32'h0, 1, 1, 0, 32'd16, 0));
        // Fill while stalled; fourth word enters as the first leaves.
        main_tbl.push_back(mk(0, 0, 1, 32'hA0A0A0A1, 0, 1, 0, 32'd16, 1));
        main_tbl.push_back(mk(0, 0, 1, 32'hA0A0A0A2, 0, 1, 0, 32'd16, 2));
        main_tbl.push_back(mk(0, 0, 1, 32'hA0A0A0A3, 0, 1, 1, 32'hA0A0A0A1, 3));
        main_tbl.push_back(mk(0, 0, 1, 32'hA0A0A0A4, 0, 0, 1, 32'hA0A0A0A1, 3));
        main_tbl.push_back(mk(0, 0, 1, 32'hA0A0A0A4, 0, 0, 1, 32'hA0A0A0A1, 3));
        main_tbl.push_back(mk(0, 0, 1, 32'hA0A0A0A4, 1, 1, 1, 32'hA0A0A0A2, 3));
        main_tbl.push_back(mk(0, 0, 0, 32'h0, 1, 1, 1, 32'hA0A0A0A3, 2));
        main_tbl.push_back(mk(0, 0, 0, 32'h0, 1, 1, 1, 32'hA0A0A0A4, 1));
        main_tbl.push_back(mk(0, 0, 0, 32'h0, 1, 1, 0, 32'hA0A0A0A4, 0));
        // Bubble collapse: second word closes up behind the stalled first.
        main_tbl.push_back(mk(0, 0, 1, 32'hB0B0B0B1, 0, 1, 0, 32'hA0A0A0A4, 1));
        main_tbl.push_back(mk(0, 0, 0, 32'h0, 0, 1, 0, 32'hA0A0A0A4, 1));
        main_tbl.push_back(mk(0, 0, 0, 32'h0, 0, 1, 1, 32'hB0B0B0B1, 1));
        main_tbl.push_back(mk(0, 0, 1, 32'hB0B0B0B2, 0, 1, 1, 32'hB0B0B0B1, 2));
        main_tbl.push_back(mk(0, 0, 0, 32'h0, 0, 1, 1, 32'hB0B0B0B1, 2));
        main_tbl.push_back(mk(0, 0, 0, 32'h0, 1, 1, 1, 32'hB0B0B0B2, 1));
        main_tbl.push_back(mk(0, 0, 0, 32'h0, 1, 1, 0, 32'hB0B0B0B2, 0));
        // Flush a full pipe with a word offered; data on the output stays.
        main_tbl.push_back(mk(0, 0, 1, 32'hC0C0C0C1, 0, 1, 0, 32'hB0B0B0B2, 1));
        main_tbl.push_back(mk(0, 0, 1, 32'hC0C0C0C2, 0, 1, 0, 32'hB0B0B0B2, 2));
        main_tbl.push_back(mk(0, 0, 1, 32'hC0C0C0C3, 0, 1, 1, 32'hC0C0C0C1, 3));
        main_tbl.push_back(mk(0, 1, 1, 32'h12345678, 0, 0, 0, 32'hC0C0C0C1, 0));
        main_tbl.push_back(mk(0, 0, 1, 32'hD00DF00D, 1, 1, 0, 32'hC0C0C0C1, 1));
        main_tbl.push_back(mk(0, 0, 0, 32'h0, 1, 1, 0, 32'hC0C0C0C1, 1));
        main_tbl.push_back(mk(0, 0, 0, 32'h0, 1, 1, 1, 32'hD00DF00D, 1));
        main_tbl.push_back(mk(0, 0, 0, 32'h0, 1, 1, 0, 32'hD00DF00D, 0));

        // Single-bit, single-stage instance with alternating downstream ready.
        edge_tbl.push_back(mk(1, 0, 0, 32'h0, 0, 0, 0, 32'h0, 0));
        edge_tbl.push_back(mk(0, 0, 1, 32'h1, 1, 1, 1, 32'h1, 1));
        edge_tbl.push_back(mk(0, 0, 1, 32'h0, 0, 0, 1, 32'h1, 1));
        edge_tbl.push_back(mk(0, 0, 1, 32'h0, 1, 1, 1, 32'h0, 1));
        edge_tbl.push_back(mk(0, 0, 1, 32'h1, 0, 0, 1, 32'h0, 1));
        edge_tbl.push_back(mk(0, 0, 1, 32'h1, 1, 1, 1, 32'h1, 1));
        edge_tbl.push_back(mk(0, 0, 0, 32'h0, 0, 0, 1, 32'h1, 1));
        edge_tbl.push_back(mk(0, 0, 0, 32'h0, 1, 1, 0, 32'h1, 0));

        for (int i = 0; i < main_tbl.size(); i++) apply_main(main_tbl[i], $sformatf("main[%0d]", i));

        m_last = '0;
        apply_main(model_step(1, 0, 0, 32'h0, 0), "rand_reset");
        for (int i = 0; i < 600; i++) begin
            logic r, f, iv, ordy;
            logic [31:0] dat;
            r    = ($urandom % 150) == 0;
            f    = ($urandom % 30) == 0;
            iv   = ($urandom % 4) != 0;
            ordy = ($urandom % 3) != 0;
            dat  = $urandom;
            apply_main(model_step(r, f, iv, dat, ordy), $sformatf("rand[%0d]", i));
        end

        for (int i = 0; i < edge_tbl.size(); i++) apply_edge(edge_tbl[i], $sformatf("edge[%0d]", i));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/bus_pipe_array.md
Name: bus_pipe_array

Overview:
- Parametrised successor to the fixed-width bus capture register.
- CHANNELS lanes of WIDTH bits each, packed into one bus, carried through a DEPTH-stage elastic pipeline with a valid/ready handshake on both sides.
- Bubbles collapse: a stalled output does not stall upstream stages while empty slots remain.
- Also provides an occupancy count and a synchronous flush. Used as a VPI co-simulation test cell for multi-bit bus crossings.

Parameters:
- WIDTH, 8, bits per channel (>=1).
- CHANNELS, 4, lanes packed into the data bus (>=1).
- DEPTH, 2, pipeline stages (>=1). DEPTH=0 is illegal and must fail elaboration.
- Derived localparams (not overridable): DW = WIDTH*CHANNELS; CW = $clog2(DEPTH+1).

Ports:
- CLK  input  1  rising-edge clock; the only clock.
- RST  input  1  synchronous, active-high reset.
- FLUSH  input  1  synchronous clear of all valid bits; data is kept.
- IN_VALID  input  1  upstream word present.
- IN_READY  output  1  block accepts the word this cycle.
- IN_DATA  input  DW  lane k = IN_DATA[k*WIDTH +: WIDTH].
- OUT_VALID  output  1  valid flag of the last stage.
- OUT_READY  input  1  downstream accepts.
- OUT_DATA  output  DW  data of the last stage.
- COUNT  output  CW  number of valid stages, 0..DEPTH.

Behaviour:
- Storage: stages s0..s(DEPTH-1), each holding valid v[i] and data d[i]. s0 faces input; s(DEPTH-1) drives OUT_VALID and OUT_DATA directly from registers.
- Ready chain (combinational):
  - r[DEPTH] = OUT_READY.
  - r[i] = !v[i] | r[i+1].
  - IN_READY = r[0] & !FLUSH & !RST.
- Per clock, when not RST and not FLUSH, for each i with r[i]=1:
  - v[i] <= v[i-1], where v[-1] = IN_VALID.
  - d[i] <= d[i-1] only if v[i-1]=1, where d[-1] = IN_DATA. Otherwise d[i] holds.
  - Stages with r[i]=0 hold v and d.
- Transfer definitions:
  - Input transfer = IN_VALID & IN_READY.
  - Output transfer = OUT_VALID & OUT_READY.
  - Data is never duplicated or dropped except by FLUSH/RST.
- Latency: a word accepted at edge N appears on OUT_DATA after edge N+DEPTH-1 when downstream never stalls. Sustained throughput is 1 word/cycle.
- Full condition: all v=1 and OUT_READY=0 gives IN_READY=0. If all v=1 and OUT_READY=1, IN_READY=1, so a simultaneous output and input transfer occurs; COUNT is unchanged.
- Empty condition: COUNT=0 and OUT_VALID=0. OUT_DATA holds the last value.
- COUNT is the registered population count of v. It updates in the same edge as v:
  - +1 on input transfer only.
  - -1 on output transfer only.
  - unchanged on both or neither.
  - It never exceeds DEPTH and never underflows.
- FLUSH=1 at an edge:
  - all v <= 0; COUNT <= 0.
  - d unchanged.
  - IN_READY forced 0 that cycle, so no input is accepted.
  - An output transfer seen by downstream in that cycle is still counted as delivered.
- RST=1 at an edge (dominates FLUSH):
  - all v <= 0, all d <= 0, COUNT <= 0.
  - IN_READY forced 0 while RST is high.
  - Reset mid-stream discards all contents.
- Reset values of outputs: OUT_VALID=0, OUT_DATA=0, COUNT=0, IN_READY=0 while RST high. After RST deasserts, IN_READY=1.
- Lanes are fully independent bit slices. No reordering, no arithmetic on data.
- No combinational path from IN_VALID/IN_DATA to any output. OUT_READY feeds IN_READY combinationally through the ready chain; this path is accepted.

Test Plan (WIDTH=8, CHANNELS=4, DEPTH=3 unless noted):
1. Reset: hold RST 2 cycles with IN_VALID=1, IN_DATA=32'hDEADBEEF -> OUT_VALID=0, OUT_DATA=0, COUNT=0, IN_READY=0; after release IN_READY=1 and nothing was captured.
2. Streaming: OUT_READY=1, push 32'h00000001..32'h00000010 back-to-back -> each word appears on OUT_DATA 2 cycles after its accepting edge, in order, with no gaps; COUNT settles at 3.
3. Fill/stall: OUT_READY=0, push 32'hA0A0A0A1, 32'hA0A0A0A2, 32'hA0A0A0A3, 32'hA0A0A0A4 -> first three accepted, 4th blocked (IN_READY=0), COUNT=3. Then raise OUT_READY -> outputs A1, A2, A3, A4 in order, and the 4th is accepted in the same cycle the first word leaves.
4. Bubble collapse: send one word, 2 idle cycles, then a second word with OUT_READY=0 -> the words occupy s2 and s1 (adjacent), COUNT=2, IN_READY=1.
5. Flush: with COUNT=3, assert FLUSH for 1 cycle while IN_VALID=1 with 32'h12345678 -> COUNT=0, OUT_VALID=0, 32'h12345678 not accepted, OUT_DATA unchanged; next accepted word flows normally.
6. Edge config WIDTH=1, CHANNELS=1, DEPTH=1: alternate OUT_READY 1/0 while pushing 1,0,1 -> one word of latency after acceptance, no loss, COUNT is never above 1.
